// File: rtl/qspi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : qspi_bus_arbiter
// Description : Two-port arbiter for one external QSPI flash pin set.
//               Grants whole chip-select transactions round-robin, forces
//               the pins idle for a CS-high guard time between owners and
//               revokes a grant that lasts too long (hold timeout).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               reqN/gntN/abortN  - per-port request, grant, timeout pulse
//               sclkN/csN_n/qdoN/oeN/qdiN - per-port pin-side signals
//               sclk/cs_n/qdo/oe/qdi      - flash pad side
// Revision    : 1.0 - initial release
// ============================================================================
module qspi_bus_arbiter #(
  parameter int GUARD_CYC = 4,
  parameter int TIMEOUT   = 65535,
  parameter int TO_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  // port 0
  input  logic       req0,
  output logic       gnt0,
  output logic       abort0,
  input  logic       sclk0,
  input  logic       cs0_n,
  input  logic [3:0] qdo0,
  input  logic [3:0] oe0,
  output logic [3:0] qdi0,
  // port 1
  input  logic       req1,
  output logic       gnt1,
  output logic       abort1,
  input  logic       sclk1,
  input  logic       cs1_n,
  input  logic [3:0] qdo1,
  input  logic [3:0] oe1,
  output logic [3:0] qdi1,
  // flash pads
  output logic       sclk,
  output logic       cs_n,
  output logic [3:0] qdo,
  output logic [3:0] oe,
  input  logic [3:0] qdi
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT0 = 3'd1,
    ST_GRANT1 = 3'd2,
    ST_ABORT  = 3'd3,
    ST_GUARD  = 3'd4
  } state_t;

  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [GW-1:0]   C_GUARD_LOAD = GW'(GUARD_CYC - 1);
  localparam logic [TO_W-1:0] C_TO_LAST    = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
  localparam logic            C_TO_EN      = (TIMEOUT != 0);

  state_t            r_state;
  state_t            w_next;
  logic              r_last;      // port that owned the bus most recently
  logic [GW-1:0]     r_guard_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_abort0;
  logic              r_abort1;

  // Next-state logic. Release is tested before the timeout so that a
  // release coinciding with expiry is treated as a normal release.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req0 && (!req1 || r_last)) begin
          w_next = ST_GRANT0;
        end else if (req1) begin
          w_next = ST_GRANT1;
        end
      end
      ST_GRANT0: begin
        if (!req0 && cs0_n) begin
          w_next = ST_GUARD;
        end else if (C_TO_EN && (r_to_cnt == C_TO_LAST)) begin
          w_next = ST_ABORT;
        end
      end
      ST_GRANT1: begin
        if (!req1 && cs1_n) begin
          w_next = ST_GUARD;
        end else if (C_TO_EN && (r_to_cnt == C_TO_LAST)) begin
          w_next = ST_ABORT;
        end
      end
      ST_ABORT: w_next = ST_GUARD;
      ST_GUARD: begin
        if (r_guard_cnt == '0) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last      <= 1'b1;
      r_guard_cnt <= C_GUARD_LOAD;
      r_to_cnt    <= '0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_abort0    <= 1'b0;
      r_abort1    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_gnt0   <= (w_next == ST_GRANT0);
      r_gnt1   <= (w_next == ST_GRANT1);
      r_abort0 <= (r_state == ST_GRANT0) && (w_next == ST_ABORT);
      r_abort1 <= (r_state == ST_GRANT1) && (w_next == ST_ABORT);

      if ((w_next == ST_GRANT0) && (r_state != ST_GRANT0)) begin
        r_last <= 1'b0;
      end else if ((w_next == ST_GRANT1) && (r_state != ST_GRANT1)) begin
        r_last <= 1'b1;
      end

      // Held at zero outside a grant, so every grant starts counting from 0.
      if ((r_state == ST_GRANT0) || (r_state == ST_GRANT1)) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end

      // Preloaded while outside GUARD; counts down GUARD_CYC cycles inside it.
      if (r_state != ST_GUARD) begin
        r_guard_cnt <= C_GUARD_LOAD;
      end else if (r_guard_cnt != '0) begin
        r_guard_cnt <= r_guard_cnt - 1'b1;
      end
    end
  end

  // Pin mux driven from the registered state only; any non-grant state
  // presents an idle bus (CS high, clock low, no drivers enabled).
  always_comb begin
    sclk = 1'b0;
    cs_n = 1'b1;
    qdo  = 4'h0;
    oe   = 4'h0;
    qdi0 = 4'hF;
    qdi1 = 4'hF;
    case (r_state)
      ST_GRANT0: begin
        sclk = sclk0;
        cs_n = cs0_n;
        qdo  = qdo0;
        oe   = oe0;
        qdi0 = qdi;
      end
      ST_GRANT1: begin
        sclk = sclk1;
        cs_n = cs1_n;
        qdo  = qdo1;
        oe   = oe1;
        qdi1 = qdi;
      end
      default: ;
    endcase
  end

  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign abort0 = r_abort0;
  assign abort1 = r_abort1;

endmodule
`default_nettype wire
